score_display_driver: RTL

- Registered, parametrised 7-segment driver for the blackjack board. It replaces the combinational per-hand tens/ones split.
- Converts NUM_HANDS binary hand scores to DIGITS decimal digits each, using a shared sequential shift-add-3 (double-dabble) engine.
- Drives a 4-glyph status banner with optional blinking.
- Sits between the game FSM (scores, status code) and the HEX pins.
- All segment outputs are active-low, bit order g..a (bit6=g, bit0=a).

---
 rtl/score_display_driver_if.sv | 26 ++
 rtl/score_display_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/score_display_driver_if.sv
// Bundle between the game FSM (master) and the score display driver (slave).
// Carries the score update request, banner select, and the active-low segment outputs.
interface score_display_driver_if #(
  parameter int NUM_HANDS = 2,
  parameter int SCORE_W   = 5,
  parameter int DIGITS    = 2
);
  logic                          update;
  logic [NUM_HANDS*SCORE_W-1:0]  scores;
  logic [2:0]                    msg_code;
  logic                          msg_blink;
  logic                          busy;
  logic                          done;
  logic [NUM_HANDS*DIGITS*7-1:0] hand_segs;
  logic [27:0]                   msg_segs;

  modport master (
    output update, scores, msg_code, msg_blink,
    input  busy, done, hand_segs, msg_segs
  );

  modport slave (
    input  update, scores, msg_code, msg_blink,
    output busy, done, hand_segs, msg_segs
  );
endinterface

// File: rtl/score_display_driver.sv
// Registered 7-seg driver: shared double-dabble engine, done NUM_HANDS*(SCORE_W+2)+1 cycles after update.
// Banner has 1-cycle latency; updates while busy collapse into a single restart (no backpressure).
module score_display_driver #(
  parameter int NUM_HANDS = 2,
  parameter int SCORE_W   = 5,
  parameter int DIGITS    = 2,
  parameter int BLANK_LZ  = 1,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  score_display_driver_if.slave io_disp
);
  // Nibble count of the BCD engine: ceil(SCORE_W*log10(2)+1), never narrower than DIGITS.
  localparam int NB_CALC = (SCORE_W * 30103 + 99999) / 100000 + 1;
  localparam int NB      = (NB_CALC > DIGITS) ? NB_CALC : DIGITS;
  localparam int CH_W    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int SC_W    = $clog2(SCORE_W + 1);
  localparam int BK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HS_W    = DIGITS * 7;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_FINISH} state_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] n);
    case (n)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = G_BLANK;
    endcase
  endfunction

  function automatic logic [27:0] banner(input logic [2:0] c);
    case (c)
      3'd1:    banner = {7'h21, 7'h06, 7'h08, 7'h47}; // dEAL
      3'd2:    banner = {7'h0C, 7'h47, 7'h08, 7'h11}; // PLAY
      3'd3:    banner = {7'h41, 7'h41, 7'h79, 7'h2B}; // UUIn
      3'd4:    banner = {7'h47, 7'h40, 7'h12, 7'h06}; // LOSE
      3'd5:    banner = {7'h0C, 7'h41, 7'h12, 7'h09}; // PUSH
      3'd6:    banner = {7'h03, 7'h61, G_BLANK, G_BLANK}; // bJ
      3'd7:    banner = {7'h03, 7'h41, 7'h12, 7'h07}; // bUSt
      default: banner = {4{G_BLANK}};
    endcase
  endfunction

  function automatic logic [HS_W-1:0] reset_hand();
    for (int d = 0; d < DIGITS; d++)
      reset_hand[7*d +: 7] = (d == 0 || BLANK_LZ == 0) ? 7'h40 : G_BLANK;
  endfunction

  function automatic logic [HS_W-1:0] encode_hand(input logic [4*NB-1:0] bcd);
    logic ovf;
    logic lead;
    ovf  = 1'b0;
    lead = 1'b1;
    encode_hand = '0;
    for (int k = DIGITS; k < NB; k++)
      if (bcd[4*k +: 4] != 4'd0) ovf = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lead = lead && (bcd[4*d +: 4] == 4'd0);
      if (ovf)
        encode_hand[7*d +: 7] = G_DASH;
      else if (BLANK_LZ != 0 && lead && d != 0)
        encode_hand[7*d +: 7] = G_BLANK;
      else
        encode_hand[7*d +: 7] = digit_glyph(bcd[4*d +: 4]);
    end
  endfunction

  localparam logic [HS_W-1:0] HAND_RST = reset_hand();

  state_t                        r_state;
  state_t                        w_next_state;
  logic [NUM_HANDS*SCORE_W-1:0]  r_shadow;
  logic [CH_W-1:0]               r_ch;
  logic [SC_W-1:0]               r_cnt;
  logic [SCORE_W-1:0]            r_sh;
  logic [4*NB-1:0]               r_bcd;
  logic [4*NB-1:0]               w_bcd_adj;
  logic [HS_W-1:0]               w_enc;
  logic [NUM_HANDS*HS_W-1:0]     r_stage;
  logic [NUM_HANDS*HS_W-1:0]     r_hand_segs;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_pending;
  logic [2:0]                    r_code;
  logic [BK_W-1:0]               r_blink_cnt;
  logic                          r_phase;

  logic w_capture, w_load, w_shift, w_store, w_finish;
  logic w_last_ch, w_last_bit;

  assign w_last_ch  = (r_ch == CH_W'(NUM_HANDS - 1));
  assign w_last_bit = (r_cnt == SC_W'(SCORE_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (io_disp.update) w_next_state = S_LOAD;
      S_LOAD:   w_next_state = S_SHIFT;
      S_SHIFT:  if (w_last_bit) w_next_state = S_STORE;
      S_STORE:  w_next_state = w_last_ch ? S_FINISH : S_LOAD;
      S_FINISH: w_next_state = (r_pending || io_disp.update) ? S_LOAD : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_store   = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE:   w_capture = io_disp.update;
      S_LOAD:   w_load    = 1'b1;
      S_SHIFT:  w_shift   = 1'b1;
      S_STORE:  w_store   = 1'b1;
      S_FINISH: begin
        w_finish  = 1'b1;
        w_capture = r_pending | io_disp.update;
      end
      default: ;
    endcase
  end

  // Add-3 correction on every nibble >= 5 ahead of the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NB; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  assign w_enc = encode_hand(r_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_bcd       <= '0;
      r_stage     <= {NUM_HANDS{HAND_RST}};
      r_hand_segs <= {NUM_HANDS{HAND_RST}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_shadow <= io_disp.scores;
        r_ch     <= '0;
      end else if (w_store && !w_last_ch) begin
        r_ch <= r_ch + CH_W'(1);
      end
      if (w_load) begin
        r_bcd <= '0;
        r_sh  <= r_shadow[int'(r_ch)*SCORE_W +: SCORE_W];
        r_cnt <= '0;
      end else if (w_shift) begin
        {r_bcd, r_sh} <= {w_bcd_adj, r_sh} << 1;
        r_cnt         <= r_cnt + SC_W'(1);
      end
      if (w_store) r_stage[int'(r_ch)*HS_W +: HS_W] <= w_enc;
      // All hands flip together so the display never shows a half-updated board.
      if (w_finish) r_hand_segs <= r_stage;
      if (w_capture)     r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;
      if (w_finish)                              r_pending <= 1'b0;
      else if (r_state != S_IDLE && io_disp.update) r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code      <= 3'd0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_code <= io_disp.msg_code;
      if (!io_disp.msg_blink || io_disp.msg_code != r_code) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else if (r_blink_cnt == BK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BK_W'(1);
      end
    end
  end

  assign io_disp.busy      = r_busy;
  assign io_disp.done      = r_done;
  assign io_disp.hand_segs = r_hand_segs;
  assign io_disp.msg_segs  = r_phase ? banner(r_code) : {4{G_BLANK}};
endmodule
